hamming_pipe_decoder: RTL and testbench

Parametrised, two-stage pipelined Hamming decoder for the (2^R−1, 2^R−1−R) code family, with an optional extended-parity (SECDED) mode. It computes the syndrome and corrects the erroneous bit, using the same one-hot XOR correction as the fixed (15,11) decoder. It then strips the parity bits and delivers data over a valid/ready handshake with full backpressure. It sits between the channel receive buffer and the data sink, and keeps saturating counts of corrected and uncorrectable words.

---
 rtl/hamming_pipe_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_hamming_pipe_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_pipe_decoder.sv
// -----------------------------------------------------------------------------
// hamming_pipe_decoder
//
// Two-stage pipelined Hamming decoder for the (2^R-1, 2^R-1-R) code family,
// with an optional extended overall-parity bit (SECDED). Stage 1 registers
// the raw codeword, its syndrome and the overall parity. Stage 2 flips the
// indicated bit, strips the parity positions and registers data plus flags.
// It also keeps saturating counts of corrected and uncorrectable words.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until accepted.
// Ready may depend combinationally on downstream ready but never on valid.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_code         codeword; in_code[i] is position i+1; in_code[N] is the
//                   overall even-parity bit when EXT=1
//   in_valid/ready  input handshake
//   out_data        corrected data bits (non-power-of-two positions, ascending)
//   out_syndrome    syndrome of the delivered word
//   out_err_corr    a single error was corrected
//   out_err_uncorr  double error detected (EXT=1 only)
//   out_valid/ready output handshake
//   clr_cnt         synchronous clear of both counters (wins over increment)
//   corr_cnt        saturating count of delivered corrected words
//   uncorr_cnt      saturating count of delivered uncorrectable words
// -----------------------------------------------------------------------------
module hamming_pipe_decoder #(
    parameter int R     = 4,
    parameter int EXT   = 0,
    parameter int CNT_W = 16,
    localparam int N    = (1 << R) - 1,
    localparam int K    = N - R,
    localparam int W    = N + EXT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [K-1:0]     out_data,
    output logic [R-1:0]     out_syndrome,
    output logic             out_err_corr,
    output logic             out_err_uncorr,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    // Codeword position (1-based) that carries data bit idx.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Positions whose index has bit b set; syndrome bit b is the XOR over them.
    function automatic logic [N-1:0] syn_mask(input int b);
        logic [N-1:0] m;
        m = '0;
        for (int p = 1; p <= N; p++) begin
            if (((p >> b) & 1) != 0) m = m | (N'(1) << (p - 1));
        end
        return m;
    endfunction

    // ---------------- pipeline state ----------------
    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_code_q,  s1_code_d;
    logic [R-1:0]     s1_syn_q,   s1_syn_d;
    logic             s1_par_q,   s1_par_d;

    logic             s2_valid_q,  s2_valid_d;
    logic [K-1:0]     s2_data_q,   s2_data_d;
    logic [R-1:0]     s2_syn_q,    s2_syn_d;
    logic             s2_corr_q,   s2_corr_d;
    logic             s2_uncorr_q, s2_uncorr_d;

    logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic             s1_en;
    logic             s2_en;
    logic             out_fire;

    // ---------------- stage 1 combinational ----------------
    logic [R-1:0]     syn_w;
    logic             par_w;

    for (genvar b = 0; b < R; b++) begin : g_syn
        localparam logic [N-1:0] MASK = syn_mask(b);
        assign syn_w[b] = ^(in_code[N-1:0] & MASK);
    end

    // Overall parity covers all N+EXT bits; only meaningful in SECDED mode.
    assign par_w = (EXT != 0) ? ^in_code : 1'b0;

    // ---------------- stage 2 combinational ----------------
    logic             syn_nz;
    logic             apply_flip;
    logic             flag_corr;
    logic             flag_uncorr;
    logic [N-1:0]     flip_vec;
    logic [N-1:0]     fixed_code;
    logic [K-1:0]     data_strip;

    assign syn_nz = |s1_syn_q;

    always_comb begin : decode_flags
        apply_flip  = 1'b0;
        flag_corr   = 1'b0;
        flag_uncorr = 1'b0;
        if (EXT == 0) begin
            apply_flip = syn_nz;
            flag_corr  = syn_nz;
        end else begin
            // P=1 means an odd number of flips: single error, either at
            // position s or (s=0) on the overall-parity bit itself.
            apply_flip  = syn_nz && s1_par_q;
            flag_corr   = s1_par_q;
            flag_uncorr = syn_nz && !s1_par_q;
        end
    end

    // One-hot flip vector: bit s-1 set when a correction applies.
    for (genvar g = 0; g < N; g++) begin : g_flip
        assign flip_vec[g] = apply_flip && (s1_syn_q == R'(g + 1));
    end

    assign fixed_code = s1_code_q ^ flip_vec;

    for (genvar g = 0; g < K; g++) begin : g_data
        localparam int POS = data_pos(g);
        assign data_strip[g] = fixed_code[POS-1];
    end

    // ---------------- next-state logic ----------------
    always_comb begin : next_state
        s2_en    = !s2_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_ready = s1_en;
        out_fire = s2_valid_q && out_ready;

        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_syn_d    = s2_syn_q;
        s2_corr_d   = s2_corr_q;
        s2_uncorr_d = s2_uncorr_q;

        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code[N-1:0];
                s1_syn_d  = syn_w;
                s1_par_d  = par_w;
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = data_strip;
                s2_syn_d    = s1_syn_q;
                s2_corr_d   = flag_corr;
                s2_uncorr_d = flag_uncorr;
            end
        end

        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire) begin
            if (s2_corr_q && (corr_cnt_q != '1))
                corr_cnt_d = corr_cnt_q + 1'b1;
            if (s2_uncorr_q && (uncorr_cnt_q != '1))
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_syn_q     <= '0;
            s2_corr_q    <= 1'b0;
            s2_uncorr_q  <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_syn_q     <= s2_syn_d;
            s2_corr_q    <= s2_corr_d;
            s2_uncorr_q  <= s2_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = s2_data_q;
    assign out_syndrome   = s2_syn_q;
    assign out_err_corr   = s2_corr_q;
    assign out_err_uncorr = s2_uncorr_q;
    assign corr_cnt       = corr_cnt_q;
    assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_pipe_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_pipe_decoder
//
// Two instances: dut0 is the plain (15,11) decoder with 2-bit counters,
// dut1 is the (16,11) SECDED decoder with 16-bit counters. Directed
// codewords carry hand-computed expected words {data, syndrome, corr, uncorr}
// that are queued on acceptance and popped by a monitor on every output
// handshake.
// -----------------------------------------------------------------------------
module tb_hamming_pipe_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: R=4, EXT=0, CNT_W=2
    logic [14:0] in_code0 = '0;
    logic        in_valid0 = 1'b0, in_ready0;
    logic [10:0] out_data0;
    logic [3:0]  out_syndrome0;
    logic        out_err_corr0, out_err_uncorr0, out_valid0;
    logic        out_ready0 = 1'b1, clr_cnt0 = 1'b0;
    logic [1:0]  corr_cnt0, uncorr_cnt0;

    // dut1: R=4, EXT=1, CNT_W=16
    logic [15:0] in_code1 = '0;
    logic        in_valid1 = 1'b0, in_ready1;
    logic [10:0] out_data1;
    logic [3:0]  out_syndrome1;
    logic        out_err_corr1, out_err_uncorr1, out_valid1;
    logic        out_ready1 = 1'b1, clr_cnt1 = 1'b0;
    logic [15:0] corr_cnt1, uncorr_cnt1;

    hamming_pipe_decoder #(.R(4), .EXT(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst),
        .in_code(in_code0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_syndrome(out_syndrome0),
        .out_err_corr(out_err_corr0), .out_err_uncorr(out_err_uncorr0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .clr_cnt(clr_cnt0), .corr_cnt(corr_cnt0), .uncorr_cnt(uncorr_cnt0)
    );

    hamming_pipe_decoder #(.R(4), .EXT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_code(in_code1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_syndrome(out_syndrome1),
        .out_err_corr(out_err_corr1), .out_err_uncorr(out_err_uncorr1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .clr_cnt(clr_cnt1), .corr_cnt(corr_cnt1), .uncorr_cnt(uncorr_cnt1)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp0_q[$];
    logic [16:0] exp1_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [16:0] mk(input logic [10:0] d, input logic [3:0] s,
                                       input logic c, input logic u);
        return {d, s, c, u};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every delivered word with the head of its queue.
    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] e;
        if (!rst && out_valid0 && out_ready0) begin
            act = {out_data0, out_syndrome0, out_err_corr0, out_err_uncorr0};
            checks++;
            if (exp0_q.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_word: got 0x%0h expected none", act);
            end else begin
                e = exp0_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL dut0_word: got 0x%0h expected 0x%0h", act, e);
                end
            end
        end
        if (!rst && out_valid1 && out_ready1) begin
            act = {out_data1, out_syndrome1, out_err_corr1, out_err_uncorr1};
            checks++;
            if (exp1_q.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_word: got 0x%0h expected none", act);
            end else begin
                e = exp1_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL dut1_word: got 0x%0h expected 0x%0h", act, e);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send0(input logic [14:0] code, input logic [16:0] exp);
        in_code0  = code;
        in_valid0 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready0) break;
        end
        chk("send0_accept", in_ready0, 1);
        if (in_ready0) exp0_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] code, input logic [16:0] exp);
        in_code1  = code;
        in_valid1 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready1) break;
        end
        chk("send1_accept", in_ready1, 1);
        if (in_ready1) exp1_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
        end
        chk("drain_pending", exp0_q.size() + exp1_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_in_ready0",  in_ready0,  1);
        chk("rst_out_data0",  out_data0,  0);
        chk("rst_corr_cnt0",  corr_cnt0,  0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_uncorr_cnt1", uncorr_cnt1, 0);
        @(posedge clk);
        #1;

        // Plain Hamming(15,11)
        send0(15'h7FFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        send0(15'h7FBF, mk(11'h7FF, 4'd7, 1'b1, 1'b0));   // position 7 flipped
        drain();
        chk("corr_cnt0_after_one", corr_cnt0, 1);
        send0(15'h0000, mk(11'h000, 4'd0, 1'b0, 1'b0));
        send0(15'h0007, mk(11'h001, 4'd0, 1'b0, 1'b0));   // data bit at pos 3
        send0(15'h408B, mk(11'h400, 4'd0, 1'b0, 1'b0));   // data bit at pos 15
        send0(15'h0004, mk(11'h000, 4'd3, 1'b1, 1'b0));   // pos 3 flipped
        send0(15'h0001, mk(11'h000, 4'd1, 1'b1, 1'b0));   // parity pos 1 flipped
        drain();
        chk("corr_cnt0_three", corr_cnt0, 3);
        chk("uncorr_cnt0_zero", uncorr_cnt0, 0);

        // Clear with no handshake in flight
        clr_cnt0 = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt0 = 1'b0;
        @(negedge clk);
        chk("corr_cnt0_cleared", corr_cnt0, 0);
        @(posedge clk);
        #1;

        // Saturation: five corrected words into a 2-bit counter
        send0(15'h7FFE, mk(11'h7FF, 4'd1,  1'b1, 1'b0));
        send0(15'h7FFD, mk(11'h7FF, 4'd2,  1'b1, 1'b0));
        send0(15'h7FEF, mk(11'h7FF, 4'd5,  1'b1, 1'b0));
        send0(15'h77FF, mk(11'h7FF, 4'd12, 1'b1, 1'b0));
        send0(15'h3FFF, mk(11'h7FF, 4'd15, 1'b1, 1'b0));
        drain();
        chk("corr_cnt0_saturated", corr_cnt0, 3);

        // Sixth corrected word delivered in the same cycle as clr_cnt
        out_ready0 = 1'b0;
        send0(15'h7F7F, mk(11'h7FF, 4'd8, 1'b1, 1'b0));   // parity pos 8 flipped
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid0) break;
        end
        chk("clr_word_ready", out_valid0, 1);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        clr_cnt0   = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt0 = 1'b0;
        @(negedge clk);
        chk("corr_cnt0_clear_wins", corr_cnt0, 0);
        @(posedge clk);
        #1;

        // Backpressure: A and B fill the pipe, C waits
        out_ready0 = 1'b0;
        send0(15'h7FFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));   // A
        send0(15'h0007, mk(11'h001, 4'd0, 1'b0, 1'b0));   // B
        in_code0  = 15'h408B;
        in_valid0 = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready0, 0);
        chk("bp_out_valid",    out_valid0, 1);
        @(negedge clk);
        chk("bp_in_ready_still_low", in_ready0, 0);
        chk("bp_out_data_held", out_data0, 11'h7FF);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        send0(15'h408B, mk(11'h400, 4'd0, 1'b0, 1'b0));   // C
        @(negedge clk);
        chk("bp_b_consecutive", out_valid0, 1);
        @(negedge clk);
        chk("bp_c_consecutive", out_valid0, 1);
        drain();

        // SECDED (16,11)
        send1(16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        send1(16'hFFEB, mk(11'h7FC, 4'd6, 1'b0, 1'b1));   // positions 3 and 5
        send1(16'h7FFF, mk(11'h7FF, 4'd0, 1'b1, 1'b0));   // overall parity bit
        send1(16'hFFEF, mk(11'h7FF, 4'd5, 1'b1, 1'b0));   // position 5
        drain();
        chk("uncorr_cnt1_one", uncorr_cnt1, 1);
        chk("corr_cnt1_two",   corr_cnt1,   2);

        // Reset with both stages full
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        send0(15'h7FBF, mk(11'h7FF, 4'd7, 1'b1, 1'b0));
        send0(15'h0000, mk(11'h000, 4'd0, 1'b0, 1'b0));
        send1(16'hFFEB, mk(11'h7FC, 4'd6, 1'b0, 1'b1));
        send1(16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        chk("full_in_ready0_low", in_ready0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp0_q.delete();
        exp1_q.delete();
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid0", out_valid0, 0);
        chk("mid_rst_in_ready0",  in_ready0,  1);
        chk("mid_rst_out_valid1", out_valid1, 0);
        chk("mid_rst_in_ready1",  in_ready1,  1);
        chk("mid_rst_corr_cnt1",  corr_cnt1,  0);
        chk("mid_rst_uncorr_cnt1", uncorr_cnt1, 0);
        @(posedge clk);
        #1;

        // Pipeline still works after reset
        send0(15'h7FBF, mk(11'h7FF, 4'd7, 1'b1, 1'b0));
        send1(16'hFFEB, mk(11'h7FC, 4'd6, 1'b0, 1'b1));
        drain();
        chk("post_rst_corr_cnt0",   corr_cnt0,   1);
        chk("post_rst_uncorr_cnt1", uncorr_cnt1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
